// File: rtl/axil_arb_pkg.sv
// ---------------------------------------------------------------------------
// axil_arb_pkg
// Shared types and constants for the AXI-Lite read arbiter slice.
//   arb_state_t      : arbiter FSM encoding (IDLE / ADDR / DATA)
//   ARB_ROUND_ROBIN  : arbitration mode select, rotating priority
//   ARB_FIXED        : arbitration mode select, master 0 highest with
//                      starvation guard
//   RESP_*           : AXI read response codes
// ---------------------------------------------------------------------------
package axil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic ARB_ROUND_ROBIN = 1'b0;
    localparam logic ARB_FIXED       = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : axil_arb_pkg

// File: rtl/axil_arb_select.sv
// ---------------------------------------------------------------------------
// axil_arb_select
// Purely combinational winner selection for the read arbiter.
// Ports:
//   req         : per-master request (arvalid) vector
//   last        : index of the master that completed the previous read
//   sat         : per-master wait-counter saturation flags (fixed mode)
//   mode        : ARB_ROUND_ROBIN or ARB_FIXED
//   winner      : selected master index (meaningful when any_request)
//   any_request : at least one master is requesting
// ---------------------------------------------------------------------------
module axil_arb_select
    import axil_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    input  logic [NUM_MASTERS-1:0] sat,
    input  logic                   mode,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_request
);

    logic [IDX_W-1:0]       rr_idx_s;
    logic [IDX_W-1:0]       rr_cand_s;
    logic [IDX_W-1:0]       fixed_idx_s;
    logic [IDX_W-1:0]       sat_idx_s;
    logic [NUM_MASTERS-1:0] sat_req_s;
    logic                   sat_hit_s;

    assign any_request = |req;
    assign sat_req_s   = req & sat;
    assign sat_hit_s   = |sat_req_s;

    // Candidate searches; loops run from the far end so the last hit
    // written is the nearest one (lowest index / first after last).
    always_comb begin
        rr_idx_s    = '0;
        rr_cand_s   = '0;
        fixed_idx_s = '0;
        sat_idx_s   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            rr_cand_s = IDX_W'((int'(last) + k) % NUM_MASTERS);
            if (req[rr_cand_s]) begin
                rr_idx_s = rr_cand_s;
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                fixed_idx_s = IDX_W'(i);
            end else begin
                fixed_idx_s = fixed_idx_s;
            end
            if (sat_req_s[i]) begin
                sat_idx_s = IDX_W'(i);
            end else begin
                sat_idx_s = sat_idx_s;
            end
        end
    end

    // Final winner: a starved master overrides fixed priority.
    always_comb begin
        winner = '0;
        if (mode == ARB_FIXED) begin
            if (sat_hit_s) begin
                winner = sat_idx_s;
            end else begin
                winner = fixed_idx_s;
            end
        end else begin
            winner = rr_idx_s;
        end
    end

endmodule : axil_arb_select

// File: rtl/axil_read_arbiter.sv
// ---------------------------------------------------------------------------
// axil_read_arbiter
// Shares one AXI-Lite read port of the sample memory between NUM_MASTERS
// read-only requesters, one transaction outstanding at a time.
// Ports:
//   aclk, aresetn         : clock, synchronous active-low reset
//   s_axil_ar*            : per-master read address channels (slice i)
//   s_axil_r*             : read data (broadcast), rvalid to owner only
//   m_axil_ar*, m_axil_r* : single read port towards the memory
//   grant                 : current / last owner index
//   busy                  : high while a transaction is in flight
// ---------------------------------------------------------------------------
module axil_read_arbiter
    import axil_arb_pkg::*;
#(
    parameter int  NUM_MASTERS   = 2,
    parameter int  ADDR_WIDTH    = 32,
    parameter int  DATA_WIDTH    = 16,
    parameter int  PRIORITY_MODE = 0,
    parameter int  MAX_WAIT      = 4,
    localparam int IDX_W         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [NUM_MASTERS*3-1:0]          s_axil_arprot,
    input  logic [NUM_MASTERS-1:0]            s_axil_arvalid,
    output logic [NUM_MASTERS-1:0]            s_axil_arready,
    output logic [DATA_WIDTH-1:0]             s_axil_rdata,
    output logic [1:0]                        s_axil_rresp,
    output logic [NUM_MASTERS-1:0]            s_axil_rvalid,
    input  logic [NUM_MASTERS-1:0]            s_axil_rready,
    output logic [ADDR_WIDTH-1:0]             m_axil_araddr,
    output logic [2:0]                        m_axil_arprot,
    output logic                              m_axil_arvalid,
    input  logic                              m_axil_arready,
    input  logic [DATA_WIDTH-1:0]             m_axil_rdata,
    input  logic [1:0]                        m_axil_rresp,
    input  logic                              m_axil_rvalid,
    output logic                              m_axil_rready,
    output logic [IDX_W-1:0]                  grant,
    output logic                              busy
);

    localparam int               CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic             MODE_L  = (PRIORITY_MODE == 1) ? ARB_FIXED : ARB_ROUND_ROBIN;

    arb_state_t             state_r;
    logic [IDX_W-1:0]       grant_r;
    logic [IDX_W-1:0]       last_r;
    logic                   busy_r;
    logic                   m_arvalid_r;
    logic [ADDR_WIDTH-1:0]  m_araddr_r;
    logic [2:0]             m_arprot_r;
    logic [CNT_W-1:0]       wait_cnt_r [NUM_MASTERS];

    logic [IDX_W-1:0]       winner_s;
    logic                   any_req_s;
    logic [NUM_MASTERS-1:0] sat_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [2:0]             sel_prot_s;
    logic [NUM_MASTERS-1:0] arready_s;
    logic [NUM_MASTERS-1:0] rvalid_s;
    logic                   m_rready_s;
    logic                   arb_cycle_s;

    // Arbitration only happens while idle with a pending request.
    assign arb_cycle_s = (state_r == IDLE) && any_req_s;

    axil_arb_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_select (
        .req         (s_axil_arvalid),
        .last        (last_r),
        .sat         (sat_s),
        .mode        (MODE_L),
        .winner      (winner_s),
        .any_request (any_req_s)
    );

    // Saturation flags and winner's address/prot mux.
    always_comb begin
        sat_s      = '0;
        sel_addr_s = '0;
        sel_prot_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sat_s[i] = (wait_cnt_r[i] == CNT_MAX);
            if (IDX_W'(i) == winner_s) begin
                sel_addr_s = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_prot_s = s_axil_arprot[i*3 +: 3];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_prot_s = sel_prot_s;
            end
        end
    end

    // Handshake steering: arready to the winner while idle, rvalid/rready
    // routed to and from the current owner while in DATA.
    always_comb begin
        arready_s  = '0;
        rvalid_s   = '0;
        m_rready_s = 1'b0;
        if (arb_cycle_s) begin
            arready_s[winner_s] = 1'b1;
        end else begin
            arready_s = '0;
        end
        if (state_r == DATA) begin
            rvalid_s[grant_r] = m_axil_rvalid;
            m_rready_s        = s_axil_rready[grant_r];
        end else begin
            rvalid_s   = '0;
            m_rready_s = 1'b0;
        end
    end

    // Arbiter FSM with registered address channel, grant and busy.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            last_r      <= IDX_W'(NUM_MASTERS - 1);
            busy_r      <= 1'b0;
            m_arvalid_r <= 1'b0;
            m_araddr_r  <= '0;
            m_arprot_r  <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r     <= ADDR;
                        busy_r      <= 1'b1;
                        grant_r     <= winner_s;
                        m_arvalid_r <= 1'b1;
                        m_araddr_r  <= sel_addr_s;
                        m_arprot_r  <= sel_prot_s;
                    end
                end
                ADDR: begin
                    if (m_arvalid_r && m_axil_arready) begin
                        state_r     <= DATA;
                        m_arvalid_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (m_axil_rvalid && m_rready_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        last_r  <= grant_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    m_arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counters: losers that were requesting count up and
    // saturate, the winner clears. Only active in fixed-priority mode.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else if ((MODE_L == ARB_FIXED) && arb_cycle_s) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (IDX_W'(i) == winner_s) begin
                    wait_cnt_r[i] <= '0;
                end else if (s_axil_arvalid[i] && (wait_cnt_r[i] != CNT_MAX)) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + CNT_W'(1);
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                wait_cnt_r[i] <= wait_cnt_r[i];
            end
        end
    end

    assign s_axil_arready = arready_s;
    assign s_axil_rvalid  = rvalid_s;
    assign s_axil_rdata   = m_axil_rdata;
    assign s_axil_rresp   = m_axil_rresp;
    assign m_axil_rready  = m_rready_s;
    assign m_axil_arvalid = m_arvalid_r;
    assign m_axil_araddr  = m_araddr_r;
    assign m_axil_arprot  = m_arprot_r;
    assign grant          = grant_r;
    assign busy           = busy_r;

endmodule : axil_read_arbiter

// File: tb/tb_axil_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_read_arbiter
// Directed bench for axil_read_arbiter. Two instances share all inputs:
// dut (round-robin) and dut_fp (fixed priority, MAX_WAIT 4). Both have
// identical timing, so one memory/master stimulus drives them in lockstep.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axil_read_arbiter;
    import axil_arb_pkg::*;

    logic        clk;
    logic        aresetn;
    logic [63:0] s_araddr;
    logic [5:0]  s_arprot;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_rready;
    logic        m_arready;
    logic [15:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;

    logic [1:0]  rr_arready, rr_rvalid, rr_rresp;
    logic [15:0] rr_rdata;
    logic [31:0] rr_m_araddr;
    logic [2:0]  rr_m_arprot;
    logic        rr_m_arvalid, rr_m_rready, rr_grant, rr_busy;

    logic [1:0]  fp_arready, fp_rvalid, fp_rresp;
    logic [15:0] fp_rdata;
    logic [31:0] fp_m_araddr;
    logic [2:0]  fp_m_arprot;
    logic        fp_m_arvalid, fp_m_rready, fp_grant, fp_busy;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int hs_before;
    logic       exp_g;
    logic [31:0] exp_a;

    axil_read_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(16),
        .PRIORITY_MODE(0), .MAX_WAIT(4)
    ) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot),
        .s_axil_arvalid(s_arvalid), .s_axil_arready(rr_arready),
        .s_axil_rdata(rr_rdata), .s_axil_rresp(rr_rresp),
        .s_axil_rvalid(rr_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(rr_m_araddr), .m_axil_arprot(rr_m_arprot),
        .m_axil_arvalid(rr_m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(rr_m_rready),
        .grant(rr_grant), .busy(rr_busy)
    );

    axil_read_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(16),
        .PRIORITY_MODE(1), .MAX_WAIT(4)
    ) dut_fp (
        .aclk(clk), .aresetn(aresetn),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot),
        .s_axil_arvalid(s_arvalid), .s_axil_arready(fp_arready),
        .s_axil_rdata(fp_rdata), .s_axil_rresp(fp_rresp),
        .s_axil_rvalid(fp_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(fp_m_araddr), .m_axil_arprot(fp_m_arprot),
        .m_axil_arvalid(fp_m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(fp_m_rready),
        .grant(fp_grant), .busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed read-data handshakes on the round-robin instance.
    always @(posedge clk) begin
        if (aresetn && rr_m_rready && m_rvalid) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn   = 1'b0;
        s_araddr  = 64'h0;
        s_arprot  = 6'b0;
        s_arvalid = 2'b00;
        s_rready  = 2'b00;
        m_arready = 1'b0;
        m_rdata   = 16'h0;
        m_rresp   = 2'b00;
        m_rvalid  = 1'b0;

        // ---- reset ----
        repeat (4) @(negedge clk);
        check("rst_arvalid", rr_m_arvalid, 64'd0);
        check("rst_araddr", rr_m_araddr, 64'd0);
        check("rst_arprot", rr_m_arprot, 64'd0);
        check("rst_grant", rr_grant, 64'd0);
        check("rst_busy", rr_busy, 64'd0);
        check("rst_arready", rr_arready, 64'd0);
        check("rst_rvalid", rr_rvalid, 64'd0);
        check("rst_mrready", rr_m_rready, 64'd0);
        check("rst_fp_busy", fp_busy, 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        check("idle_arready", rr_arready, 64'd0);
        check("idle_busy", rr_busy, 64'd0);

        // ---- single request, master 0 ----
        s_araddr[31:0] = 32'h100;
        s_arprot[2:0]  = 3'b001;
        s_arvalid      = 2'b01;
        s_rready       = 2'b11;
        #1;
        check("t1_arready_comb", rr_arready, 64'h1);
        @(negedge clk);
        check("t1_arvalid", rr_m_arvalid, 64'd1);
        check("t1_araddr", rr_m_araddr, 64'h100);
        check("t1_arprot", rr_m_arprot, 64'h1);
        check("t1_grant", rr_grant, 64'd0);
        check("t1_busy", rr_busy, 64'd1);
        check("t1_arready_addr", rr_arready, 64'd0);
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        @(negedge clk);
        check("t1_arvalid_clr", rr_m_arvalid, 64'd0);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 16'hBEEF;
        #1;
        check("t1_rvalid", rr_rvalid, 64'h1);
        check("t1_rdata", rr_rdata, 64'hBEEF);
        check("t1_mrready", rr_m_rready, 64'd1);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = 16'h0;
        #1;
        check("t1_busy_done", rr_busy, 64'd0);
        check("t1_rvalid_done", rr_rvalid, 64'd0);

        // ---- fairness / starvation with both masters requesting ----
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn   = 1'b1;
        s_araddr  = {32'h200, 32'h100};
        s_arprot  = {3'b010, 3'b001};
        s_arvalid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_g = 1'(k % 2);
            exp_a = exp_g ? 32'h200 : 32'h100;
            check($sformatf("rr_grant_%0d", k), rr_grant, 64'(exp_g));
            check($sformatf("rr_addr_%0d", k), rr_m_araddr, 64'(exp_a));
            exp_g = (k % 5 == 4) ? 1'b1 : 1'b0;
            exp_a = exp_g ? 32'h200 : 32'h100;
            check($sformatf("fp_grant_%0d", k), fp_grant, 64'(exp_g));
            check($sformatf("fp_addr_%0d", k), fp_m_araddr, 64'(exp_a));
            m_arready = 1'b1;
            @(negedge clk);
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            @(negedge clk);
            m_rvalid  = 1'b0;
        end
        s_arvalid = 2'b00;

        // ---- backpressure, master 1 ----
        s_araddr[63:32] = 32'h2A0;
        s_arvalid       = 2'b10;
        s_rready        = 2'b01;
        hs_before       = hs_cnt;
        @(negedge clk);
        check("bp_grant", rr_grant, 64'd1);
        s_arvalid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_arvalid_%0d", i), rr_m_arvalid, 64'd1);
            check($sformatf("bp_araddr_%0d", i), rr_m_araddr, 64'h2A0);
            @(negedge clk);
        end
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 16'h1234;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("bp_mrready_low_%0d", j), rr_m_rready, 64'd0);
            check($sformatf("bp_rvalid_%0d", j), rr_rvalid, 64'h2);
            check($sformatf("bp_araddr_d_%0d", j), rr_m_araddr, 64'h2A0);
            @(negedge clk);
        end
        s_rready = 2'b11;
        #1;
        check("bp_mrready_high", rr_m_rready, 64'd1);
        check("bp_rdata", rr_rdata, 64'h1234);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = 16'h0;
        #1;
        check("bp_busy_done", rr_busy, 64'd0);
        check("bp_one_transfer", 64'(hs_cnt - hs_before), 64'd1);

        // ---- error response ----
        s_araddr[31:0] = 32'h104;
        s_arvalid      = 2'b01;
        @(negedge clk);
        check("err_grant", rr_grant, 64'd0);
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rresp   = RESP_SLVERR;
        m_rdata   = 16'hDEAD;
        #1;
        check("err_rresp", rr_rresp, 64'h2);
        check("err_rvalid", rr_rvalid, 64'h1);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rresp  = 2'b00;
        m_rdata  = 16'h0;
        #1;
        check("err_idle", rr_busy, 64'd0);

        // ---- reset while in DATA ----
        s_araddr[31:0] = 32'h100;
        s_arvalid      = 2'b10;
        @(negedge clk);
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        #1;
        check("mr_busy_data", rr_busy, 64'd1);
        check("mr_rvalid_data", rr_rvalid, 64'h2);
        aresetn  = 1'b0;
        m_rvalid = 1'b0;
        @(negedge clk);
        check("mr_busy", rr_busy, 64'd0);
        check("mr_arvalid", rr_m_arvalid, 64'd0);
        check("mr_grant", rr_grant, 64'd0);
        check("mr_fp_busy", fp_busy, 64'd0);
        aresetn   = 1'b1;
        s_arvalid = 2'b11;
        #1;
        check("mr_arready_first", rr_arready, 64'h1);
        @(negedge clk);
        check("mr_grant_first", rr_grant, 64'd0);
        check("mr_arvalid_first", rr_m_arvalid, 64'd1);
        check("mr_araddr_first", rr_m_araddr, 64'h100);
        s_arvalid = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axil_read_arbiter

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
- Shares one AXI-Lite read port of the 16-bit sample memory between NUM_MASTERS read-only requesters, e.g. the Audiosystem sample fetcher and a CPU/debug reader.
- Sits between the requesters' m_axil_ar*/r* channels and the memory's s_axil_ar*/r* channels.
- One transaction outstanding at a time.
- Selectable arbitration: round-robin, or fixed priority with a starvation guard.
- Write channels bypass this block.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 16, read data width
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, master 0 highest
MAX_WAIT, 4, mode 1 only: arbitration losses after which a waiting master is forced to win

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
s_axil_araddr  input  NUM_MASTERS*ADDR_WIDTH  per-master read address, master i at slice i
s_axil_arprot  input  NUM_MASTERS*3  per-master prot
s_axil_arvalid  input  NUM_MASTERS  per-master address valid
s_axil_arready  output  NUM_MASTERS  per-master address ready
s_axil_rdata  output  DATA_WIDTH  read data, broadcast to all masters
s_axil_rresp  output  2  read response, broadcast
s_axil_rvalid  output  NUM_MASTERS  read valid, granted master only
s_axil_rready  input  NUM_MASTERS  per-master read ready
m_axil_araddr  output  ADDR_WIDTH  address to memory
m_axil_arprot  output  3  prot to memory
m_axil_arvalid  output  1  address valid to memory
m_axil_arready  input  1  memory address ready
m_axil_rdata  input  DATA_WIDTH  memory read data
m_axil_rresp  input  2  memory read response
m_axil_rvalid  input  1  memory read valid
m_axil_rready  output  1  read ready to memory
grant  output  $clog2(NUM_MASTERS)  current/last owner index
busy  output  1  high while state != IDLE

Behaviour:
- Clock and reset: single clock aclk; reset is synchronous, active-low (aresetn).
- Reset values:
  - state = IDLE; grant = 0; busy = 0.
  - m_axil_arvalid = 0; m_axil_araddr = 0; m_axil_arprot = 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 wins first.
  - All wait counters = 0.
  - All combinational outputs are low while in IDLE with no request.
- FSM states:
  - IDLE -> ADDR when any s_axil_arvalid is high.
  - ADDR -> DATA on m_axil_arvalid && m_axil_arready.
  - DATA -> IDLE on m_axil_rvalid && m_axil_rready.
- IDLE (arbitration):
  - Winner w is selected combinationally.
  - s_axil_arready[w] = 1 in that same cycle; all other arready = 0.
  - Registered at the clock edge: araddr/arprot of w into m_axil_araddr/arprot; grant <= w; m_axil_arvalid <= 1.
  - s_axil_arready is high only in IDLE, for the winner only.
- ADDR: m_axil_arvalid is held high, with address stable, until m_axil_arready; it is cleared on the handshake edge.
- DATA:
  - m_axil_rready = s_axil_rready[grant].
  - s_axil_rvalid[grant] = m_axil_rvalid; all other rvalid bits = 0.
  - s_axil_rdata/rresp are wired straight from m_axil_rdata/rresp.
  - rresp errors (SLVERR/DECERR) pass through unmodified.
  - On the handshake: last <= grant.
- Latency and throughput:
  - Request seen in cycle N gives m_axil_arvalid high in cycle N+1.
  - With a zero-wait memory, peak throughput is one read per 3 cycles.
- Round-robin (PRIORITY_MODE 0): winner is the first arvalid master searching from last+1 upward, wrapping modulo NUM_MASTERS.
- Fixed priority (PRIORITY_MODE 1):
  - Winner is normally the lowest-index arvalid master.
  - Each master has a saturating counter wait_cnt[i] of width $clog2(MAX_WAIT+1). It increments when that master's arvalid is high in an IDLE arbitration cycle and it loses. It clears when the master wins.
  - Any master with wait_cnt == MAX_WAIT overrides priority; among several such masters, the lowest index wins.
- Boundary conditions:
  - arvalid deasserted before being granted (protocol violation): no effect; only the winner's inputs are sampled.
  - A new s_axil_arvalid arriving during ADDR/DATA waits; arready stays low.
  - The granted master may hold rready low indefinitely; the arbiter stalls with no timeout.
  - Reset mid-transaction: abandon immediately and return to the reset values. The memory shares aresetn, so no response is orphaned.
  - NUM_MASTERS = 1 degenerates to a registered pass-through with the same 3-state FSM.

Decomposition:
- Package axil_arb_pkg:
  - enum logic[1:0] ArbState {IDLE, ADDR, DATA}.
  - Constants ARB_ROUND_ROBIN = 0 and ARB_FIXED = 1.
  - AXI response constants RESP_OKAY/SLVERR/DECERR.
- Sub-module axil_arb_select: purely combinational winner selection.
  - Inputs: request vector, last pointer, wait-counter saturation flags, mode.
  - Outputs: winner index and any_request.
  - The FSM, registers and counters remain in axil_read_arbiter.

Test Plan:
- Reset/single request: hold aresetn = 0 for 4 cycles, then master 0 reads 0x100 with memory returning 0xBEEF. Expect all outputs 0 during reset; m_axil_arvalid one cycle after arvalid; s_axil_rvalid[0] with rdata 0xBEEF; s_axil_rvalid[1] stays 0; grant = 0.
- Round-robin fairness (mode 0): both masters hold arvalid continuously for 6 reads. Expect grant sequence 0,1,0,1,0,1 and addresses matching each owner.
- Fixed-priority starvation (mode 1, MAX_WAIT = 4): both masters hold arvalid continuously. Expect grants 0,0,0,0,1,0,0,0,0,1.
- Backpressure: memory delays arready 5 cycles; master 1 holds rready low 3 cycles after rvalid. Expect m_axil_araddr stable throughout; m_axil_rready low until s_axil_rready[1]; exactly one completed transfer.
- Error response: memory returns rresp = 2'b10. Expect the granted master sees rresp = 2'b10 and the FSM returns to IDLE.
- Reset mid-DATA: drop aresetn while in DATA. Expect the next cycle has state IDLE, busy = 0, m_axil_arvalid = 0, and master 0 wins the first request after release.
